// File: rtl/elastic_fifo_pkg.sv
// Shared definitions for the elastic FIFO: the sizing helper and the minimum legal depth.
package elastic_fifo_pkg;

   localparam int MIN_DEPTH = 2;

   // Bits needed to hold values 0..value-1.
   function automatic int clog2(input int value);
      int result;
      int remaining;
      result    = 0;
      remaining = value - 1;
      while (remaining > 0) begin
         result++;
         remaining = remaining >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/elastic_fifo_wrap_counter.sv
// Modulo-(MAX+1) pointer used for the FIFO head and tail. It works for depths that are not powers of two.
module elastic_fifo_wrap_counter
   import elastic_fifo_pkg::*;
#(
   parameter int WIDTH_P = 2,
   parameter int MAX     = 3
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               clr,
   input  logic               inc,
   output logic [WIDTH_P-1:0] value
);

   localparam logic [WIDTH_P-1:0] MAX_V = WIDTH_P'(MAX);

   logic [WIDTH_P-1:0] value_d;
   logic [WIDTH_P-1:0] value_q;

   always_comb begin
      value_d = value_q;
      if (reset || clr) begin
         value_d = '0;
      end else if (inc) begin
         value_d = (value_q == MAX_V) ? '0 : value_q + WIDTH_P'(1);
      end
   end

   always_ff @(posedge clock) begin
      value_q <= value_d;
   end

   assign value = value_q;

endmodule

// File: rtl/elastic_fifo.sv
// Valid/ready FIFO between a producer and a consumer. Words show up at the head one cycle after they are enqueued, and there is no bypass.
module elastic_fifo
   import elastic_fifo_pkg::*;
#(
   parameter int  WIDTH = 32,
   parameter int  DEPTH = 4,
   localparam int CNT_W = clog2(DEPTH + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             enq_valid,
   output logic             enq_ready,
   input  logic [WIDTH-1:0] enq_data,
   output logic             deq_valid,
   input  logic             deq_ready,
   output logic [WIDTH-1:0] deq_data,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = clog2(DEPTH);

   if (DEPTH < MIN_DEPTH) begin : g_depth_check
      $error("elastic_fifo: DEPTH must be at least 2");
   end

   logic [WIDTH-1:0] storage_d [DEPTH];
   logic [WIDTH-1:0] storage_q [DEPTH];
   logic [CNT_W-1:0] count_d;
   logic [CNT_W-1:0] count_q;
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic             enq_fire;
   logic             deq_fire;

   // The handshake signals depend only on occupancy and reset. The partner's valid and ready never reach them.
   assign enq_ready = !reset && (count_q != CNT_W'(DEPTH));
   assign deq_valid = !reset && (count_q != '0);
   assign deq_data  = storage_q[head];
   assign count     = count_q;

   // A clear cycle drops any transfer that happens in the same cycle.
   assign enq_fire  = enq_valid && enq_ready && !clear;
   assign deq_fire  = deq_valid && deq_ready && !clear;

   elastic_fifo_wrap_counter #(.WIDTH_P(PTR_W), .MAX(DEPTH - 1)) u_head (
      .clock (clock),
      .reset (reset),
      .clr   (clear),
      .inc   (deq_fire),
      .value (head)
   );

   elastic_fifo_wrap_counter #(.WIDTH_P(PTR_W), .MAX(DEPTH - 1)) u_tail (
      .clock (clock),
      .reset (reset),
      .clr   (clear),
      .inc   (enq_fire),
      .value (tail)
   );

   always_comb begin
      storage_d = storage_q;
      if (enq_fire) begin
         storage_d[tail] = enq_data;
      end
   end

   always_comb begin
      count_d = count_q;
      if (reset || clear) begin
         count_d = '0;
      end else begin
         case ({enq_fire, deq_fire})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Storage has no reset. Entries only matter after they have been written.
   always_ff @(posedge clock) begin
      storage_q <= storage_d;
      count_q   <= count_d;
   end

   a_count_bound : assert property (@(posedge clock) disable iff (reset)
      count_q <= CNT_W'(DEPTH));

   a_deq_stable : assert property (@(posedge clock) disable iff (reset)
      (deq_valid && !deq_ready && !clear) |=> (deq_valid && $stable(deq_data)));

   a_enq_hold : assert property (@(posedge clock) disable iff (reset)
      (enq_valid && !enq_ready && !clear) |=> (enq_valid && $stable(enq_data)));

endmodule
